// File: rtl/wb_result_router_pkg.sv
// Shared write-back definitions: result-source codes, FSM states,
// instruction field positions and the result-source selector.
package wb_result_router_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;
    localparam logic [1:0] WB_ACC = 2'b11;

    localparam int DEST_LSB = 3;
    localparam int DEST_MSB = 5;
    localparam int IMM_LSB  = 8;
    localparam int IMM_MSB  = 15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_t;

    // Loads keep the old value here; memory data lands later.
    function automatic logic [7:0] wb_select(
        input logic [1:0]  src,
        input logic [15:0] ins,
        input logic [7:0]  alu,
        input logic [7:0]  acc,
        input logic [7:0]  keep
    );
        logic [7:0] v;
        case (src)
            WB_ALU:  v = alu;
            WB_IMM:  v = ins[IMM_MSB:IMM_LSB];
            WB_ACC:  v = acc;
            default: v = keep;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/wb_result_router_timeout_ctr.sv
// Load wait counter: cleared on accept, counts while enabled,
// flags the last permitted wait cycle.
module wb_timeout_ctr
    import wb_result_router_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [7:0] r_cnt;

    // Count wait cycles; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_tc = (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/wb_result_router.sv
// Write-back router: steers ALU/memory/immediate/accumulator results
// to the register file and accumulator buffer. Option: WB_BYPASS_EN.
module wb_result_router
    import wb_result_router_pkg::*;
#(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [15:0] instr,
    input  logic [1:0]  WBSrc,
    input  logic        RegWrite,
    input  logic        AccWrite,
    input  logic [7:0]  alu_result,
    input  logic [7:0]  read_data_accbuf,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic        reg_we,
    output logic [2:0]  reg_waddr,
    output logic [7:0]  reg_wdata,
    output logic        acc_we,
    output logic [7:0]  acc_wdata,
    output logic        wb_error,
`ifdef WB_BYPASS_EN
    output logic        fwd_valid,
    output logic [2:0]  fwd_addr,
    output logic [7:0]  fwd_data,
`endif
    input  logic        err_clr
);

    wb_state_t  r_state;
    wb_state_t  w_next;
    logic       w_accept;
    logic       w_load_done;
    logic       w_timeout;
    logic       w_tc;
    logic       w_wait;

    logic [2:0] r_dest;
    logic       r_regw;
    logic       r_accw;
    logic [7:0] r_result;
    logic       r_reg_we;
    logic       r_acc_we;
    logic       r_ready;
    logic       r_err;

    logic       w_unused;
    assign w_unused = ^{instr[7:6], instr[2:0]};

    assign w_wait = (r_state == ST_WAIT_MEM);

    wb_timeout_ctr #(
        .LIMIT (MEM_TIMEOUT)
    ) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_en  (w_wait),
        .o_tc  (w_tc)
    );

    // Next-state logic; memory data beats a same-cycle timeout.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_load_done = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (issue_valid) begin
                    w_accept = 1'b1;
                    w_next   = (WBSrc == WB_MEM) ? ST_WAIT_MEM : ST_WRITE;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    w_load_done = 1'b1;
                    w_next      = ST_WRITE;
                end else if (w_tc) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_WRITE: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture destination, enables and the result value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dest   <= 3'd0;
            r_regw   <= 1'b0;
            r_accw   <= 1'b0;
            r_result <= 8'd0;
        end else if (w_accept) begin
            r_dest   <= instr[DEST_MSB:DEST_LSB];
            r_regw   <= RegWrite;
            r_accw   <= AccWrite;
            r_result <= wb_select(WBSrc, instr, alu_result,
                                  read_data_accbuf, r_result);
        end else if (w_load_done) begin
            r_result <= mem_rdata;
        end
    end

    // Registered strobes and ready, timed to the WRITE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reg_we <= 1'b0;
            r_acc_we <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_reg_we <= (w_next == ST_WRITE) &
                        (w_accept ? RegWrite : r_regw);
            r_acc_we <= (w_next == ST_WRITE) &
                        (w_accept ? AccWrite : r_accw);
            r_ready  <= (w_next == ST_IDLE);
        end
    end

    // Sticky load-timeout flag; a new timeout beats a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign issue_ready = r_ready;
    assign reg_we      = r_reg_we;
    assign reg_waddr   = r_dest;
    assign reg_wdata   = r_result;
    assign acc_we      = r_acc_we;
    assign acc_wdata   = r_result;
    assign wb_error    = r_err;

`ifdef WB_BYPASS_EN
    assign fwd_valid = r_reg_we;
    assign fwd_addr  = r_dest;
    assign fwd_data  = r_result;
`endif

endmodule

// File: doc/wb_result_router.md
# wb_result_router

Write-back stage of the 8-bit datapath: accepts one issued instruction at a time and routes an 8-bit result to the register file and/or the accumulator buffer. The result is selected from the ALU result, memory read data, the instruction immediate, or the accumulator buffer. It is the return path matching the ALU operand-select stage, closing the loop from ALU/memory back to storage. Loads are multi-cycle, with a bounded wait on memory data.

## Interface
- `MEM_TIMEOUT`, default 8: maximum cycles spent in WAIT_MEM before the load is abandoned (range 2–255).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `issue_valid` in 1: an instruction is presented.
- `issue_ready` out 1: the block can accept an instruction.
- `instr` in 16: instruction word.
  - `instr[5:3]` is the destination register.
  - `instr[15:8]` is the immediate.
- `WBSrc` in 2: result source.
  - 00: ALU.
  - 01: memory.
  - 10: immediate.
  - 11: accumulator buffer.
- `RegWrite` in 1: write the result to the register file.
- `AccWrite` in 1: write the result to the accumulator buffer.
- `alu_result` in 8: ALU output, sampled at accept.
- `read_data_accbuf` in 8: accumulator buffer, sampled at accept.
- `mem_rdata` in 8: memory read data.
- `mem_rvalid` in 1: `mem_rdata` is valid this cycle.
- `reg_we` out 1: register-file write strobe.
- `reg_waddr` out 3: register-file write address.
- `reg_wdata` out 8: register-file write data.
- `acc_we` out 1: accumulator-buffer write strobe.
- `acc_wdata` out 8: accumulator-buffer write data.
- `wb_error` out 1: sticky flag; set when a load times out.
- `err_clr` in 1: clears `wb_error`.

## Operation
- FSM states: IDLE, WAIT_MEM, WRITE.
- IDLE:
  - `issue_ready`=1.
  - On `issue_valid`, capture `instr[5:3]`, `RegWrite`, `AccWrite`, and the selected source into a result register.
  - `WBSrc`=01 → WAIT_MEM, with the wait counter cleared to 0.
  - Any other `WBSrc` → WRITE.
- WAIT_MEM:
  - `issue_ready`=0. The counter increments each cycle.
  - `mem_rvalid`=1 → capture `mem_rdata` and go to WRITE. This wins over a timeout in the same cycle.
  - Counter reaches `MEM_TIMEOUT`-1 without `mem_rvalid` → set `wb_error`, no write, go to IDLE.
- WRITE:
  - One cycle. `reg_we`=`RegWrite` and `acc_we`=`AccWrite` as captured.
  - `reg_wdata` and `acc_wdata` both equal the result register.
  - Always returns to IDLE.
- If both write enables are 0, the instruction still passes through WRITE with both strobes low.
- `mem_rvalid` outside WAIT_MEM is ignored; no data is captured.
- Immediate select (10) passes `instr[15:8]` unmodified. No sign or zero extension is applied; all paths are 8 bits.
- `wb_error`:
  - Cleared by `err_clr` (synchronous).
  - Set and clear in the same cycle → set wins.
- Reset values:
  - State is IDLE, counter 0, result register 0.
  - All strobes 0, `reg_waddr`=0, data outputs 0.
  - `issue_ready`=1 from the first cycle after reset is released.
  - `wb_error`=0.
- Reset asserted mid-WAIT_MEM or in WRITE aborts the instruction; no strobe is issued on the reset edge or after it.

## Timing
- Non-load latency:
  - Accept at edge N; strobes high during cycle N+1.
  - Next accept is possible at edge N+2.
- Load latency:
  - `mem_rvalid` sampled at edge M; strobes high during cycle M+1.
  - Minimum accept-to-strobe latency is 2 cycles.
- Timeout: `wb_error` is visible `MEM_TIMEOUT` cycles after accept. `issue_ready` returns in that same cycle.
- Throughput: one instruction per 2 cycles, non-load.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `WB_BYPASS_EN` defined: adds forwarding outputs.
  - `fwd_valid` out 1, `fwd_addr` out 3, `fwd_data` out 8.
  - These mirror `reg_we`, `reg_waddr`, and `reg_wdata` in the WRITE cycle, so the operand-select stage can forward in place of a stale register read.
- `WB_BYPASS_EN` undefined: the forwarding ports are absent, and there is no forwarding logic.

## Structure
- Shared datapath package holds:
  - the `WBSrc` encodings (`WB_ALU`, `WB_MEM`, `WB_IMM`, `WB_ACC`);
  - the FSM state enum;
  - the destination-field bit positions.
- One sub-module, `wb_timeout_ctr`: the wait counter, with clear and enable inputs and a terminal-count output.

## Test plan
- ALU path: `WBSrc`=00, `alu_result`=8'h5A, `instr[5:3]`=3, `RegWrite`=1 → the cycle after accept has `reg_we`=1, `reg_waddr`=3, `reg_wdata`=8'h5A, and `acc_we`=0.
- Immediate to accumulator: `instr`=16'hF300, `WBSrc`=10, `AccWrite`=1 → `acc_we`=1 and `acc_wdata`=8'hF3 with no extension applied; `issue_ready` is low for exactly 1 cycle.
- Load: `WBSrc`=01, `mem_rvalid` asserted 3 cycles later with `mem_rdata`=8'h81 → the write occurs the following cycle with `reg_wdata`=8'h81; a stray `mem_rvalid` beforehand in IDLE produces no write.
- Timeout: `MEM_TIMEOUT`=4, no `mem_rvalid` → `wb_error`=1 after 4 cycles with no strobes; then `err_clr` → `wb_error`=0.
- Race cases:
  - `mem_rvalid` in the terminal-count cycle → the write happens and `wb_error` stays 0.
  - `err_clr` together with a new timeout → `wb_error`=1.
- Reset abort: `rst_n`=0 during WAIT_MEM → strobes stay 0, the state is IDLE, and `issue_ready`=1 on the cycle after release.
